// File: rtl/delay_line.sv
// Programmable-depth sample delay: delays a sample and its valid tag by 0..MAX_DEPTH
// clock-enabled cycles through a circular buffer, with history restart on delay change.
module delay_line #(
    parameter int WIDTH     = 12,
    parameter int MAX_DEPTH = 16,
    parameter int DW        = $clog2(MAX_DEPTH + 1)
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             EN,
    input  logic             FLUSH,
    input  logic [DW-1:0]    DELAY,
    input  logic [WIDTH-1:0] BUF_IN,
    input  logic             VALID_IN,
    output logic [WIDTH-1:0] BUF_OUT,
    output logic             OUT_VALID,
    output logic             DELAY_CLAMP
);

    localparam int PW = (MAX_DEPTH > 1) ? $clog2(MAX_DEPTH) : 1;
    localparam logic [DW-1:0] MAX_D   = DW'(MAX_DEPTH);
    localparam logic [PW-1:0] LAST_PTR = PW'(MAX_DEPTH - 1);
    localparam logic [DW:0]   MAX_W   = (DW+1)'(MAX_DEPTH);

    // Each entry holds {valid tag, data}
    logic [WIDTH:0]    mem [MAX_DEPTH];

    logic [PW-1:0]     wr_ptr_reg, wr_ptr_next;
    logic [DW-1:0]     fill_reg, fill_next;
    logic [DW-1:0]     delay_reg;
    logic [WIDTH-1:0]  buf_out_reg, buf_out_next;
    logic              out_valid_reg, out_valid_next;
    logic              clamp_reg, clamp_next;

    logic [DW-1:0]     d_eff;
    logic              restart;
    logic [DW-1:0]     fill_eff;
    logic [DW:0]       ptr_w;
    logic [DW:0]       d_w;
    logic [DW:0]       rd_idx_w;
    logic [PW-1:0]     rd_idx;
    logic [WIDTH:0]    sel;

    always_comb begin
        clamp_next = (DELAY > MAX_D);
        d_eff      = clamp_next ? MAX_D : DELAY;
        restart    = (d_eff != delay_reg);
        fill_eff   = restart ? '0 : fill_reg;

        // (wr_ptr - d) mod MAX_DEPTH without requiring a power-of-two depth
        ptr_w = (DW+1)'(wr_ptr_reg);
        d_w   = (DW+1)'(d_eff);
        if (ptr_w >= d_w)
            rd_idx_w = ptr_w - d_w;
        else
            rd_idx_w = ptr_w + MAX_W - d_w;
        rd_idx = rd_idx_w[PW-1:0];

        // d=0 bypasses storage since the current sample is not written yet
        sel = (d_eff == '0) ? {VALID_IN, BUF_IN} : mem[rd_idx];

        buf_out_next   = '0;
        out_valid_next = 1'b0;
        if (fill_eff >= d_eff) begin
            out_valid_next = sel[WIDTH];
            buf_out_next   = sel[WIDTH] ? sel[WIDTH-1:0] : '0;
        end

        wr_ptr_next = (wr_ptr_reg == LAST_PTR) ? '0 : wr_ptr_reg + 1'b1;
        fill_next   = (fill_eff == MAX_D) ? MAX_D : fill_eff + 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (!RESET && !FLUSH && EN)
            mem[wr_ptr_reg] <= {VALID_IN, BUF_IN};
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            wr_ptr_reg    <= '0;
            fill_reg      <= '0;
            delay_reg     <= '0;
            buf_out_reg   <= '0;
            out_valid_reg <= 1'b0;
            clamp_reg     <= 1'b0;
        end else if (FLUSH) begin
            wr_ptr_reg    <= '0;
            fill_reg      <= '0;
            buf_out_reg   <= '0;
            out_valid_reg <= 1'b0;
        end else if (EN) begin
            wr_ptr_reg    <= wr_ptr_next;
            fill_reg      <= fill_next;
            delay_reg     <= d_eff;
            buf_out_reg   <= buf_out_next;
            out_valid_reg <= out_valid_next;
            clamp_reg     <= clamp_next;
        end
    end

    assign BUF_OUT     = buf_out_reg;
    assign OUT_VALID   = out_valid_reg;
    assign DELAY_CLAMP = clamp_reg;

endmodule

// File: tb/tb_delay_line.sv
// Randomized and directed bench for delay_line against a queue-based history model.
module tb_delay_line;

    localparam int WIDTH     = 12;
    localparam int MAX_DEPTH = 16;
    localparam int DW        = $clog2(MAX_DEPTH + 1);

    logic             CLK = 1'b0;
    logic             RESET;
    logic             EN;
    logic             FLUSH;
    logic [DW-1:0]    DELAY;
    logic [WIDTH-1:0] BUF_IN;
    logic             VALID_IN;
    logic [WIDTH-1:0] BUF_OUT;
    logic             OUT_VALID;
    logic             DELAY_CLAMP;

    delay_line #(.WIDTH(WIDTH), .MAX_DEPTH(MAX_DEPTH)) dut (
        .CLK(CLK), .RESET(RESET), .EN(EN), .FLUSH(FLUSH), .DELAY(DELAY),
        .BUF_IN(BUF_IN), .VALID_IN(VALID_IN), .BUF_OUT(BUF_OUT),
        .OUT_VALID(OUT_VALID), .DELAY_CLAMP(DELAY_CLAMP)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference: samples accepted since the last restart, newest at the back
    logic [WIDTH:0]   hist[$];
    int               m_delay;
    logic [WIDTH-1:0] m_out;
    logic             m_valid;
    logic             m_clamp;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_edge();
        int d;
        logic [WIDTH:0] s;
        if (RESET) begin
            hist.delete();
            m_delay = 0; m_out = '0; m_valid = 1'b0; m_clamp = 1'b0;
        end else if (FLUSH) begin
            hist.delete();
            m_out = '0; m_valid = 1'b0;
        end else if (EN) begin
            d = (int'(DELAY) > MAX_DEPTH) ? MAX_DEPTH : int'(DELAY);
            m_clamp = (int'(DELAY) > MAX_DEPTH);
            if (d != m_delay) hist.delete();
            m_delay = d;
            if (hist.size() >= d) begin
                s = (d == 0) ? {VALID_IN, BUF_IN} : hist[hist.size() - d];
                m_valid = s[WIDTH];
                m_out   = s[WIDTH] ? s[WIDTH-1:0] : '0;
            end else begin
                m_out = '0; m_valid = 1'b0;
            end
            hist.push_back({VALID_IN, BUF_IN});
            if (hist.size() > MAX_DEPTH) void'(hist.pop_front());
        end
    endtask

    task automatic drive(input logic en, input logic fl, input int dly,
                         input logic [WIDTH-1:0] din, input logic vin);
        EN = en; FLUSH = fl; DELAY = DW'(dly); BUF_IN = din; VALID_IN = vin;
    endtask

    task automatic tick(input string tag);
        @(posedge CLK);
        #1;
        model_edge();
        check_val({tag, "_out"},   32'(BUF_OUT),     32'(m_out));
        check_val({tag, "_valid"}, 32'(OUT_VALID),   32'(m_valid));
        check_val({tag, "_clamp"}, 32'(DELAY_CLAMP), 32'(m_clamp));
    endtask

    initial begin
        RESET = 1'b1;
        drive(1'b0, 1'b0, 0, '0, 1'b0);
        m_delay = 0; m_out = '0; m_valid = 1'b0; m_clamp = 1'b0;
        tick("rst");
        tick("rst");
        RESET = 1'b0;

        // DELAY=3 ramp: first sample emerges after the fourth edge
        for (int k = 1; k <= 10; k++) begin
            drive(1'b1, 1'b0, 3, WIDTH'(k), 1'b1);
            tick("d3");
            check_val("d3_abs", 32'(BUF_OUT), (k >= 4) ? 32'(k - 3) : 32'd0);
        end

        drive(1'b1, 1'b0, 0, 12'hABC, 1'b1);
        tick("d0");
        check_val("d0_abc", 32'(BUF_OUT), 32'hABC);

        for (int k = 0; k < 8; k++) begin
            drive(1'b1, 1'b0, 1, WIDTH'($urandom), 1'b1);
            tick("d1");
        end

        // Full depth across several pointer wraps
        for (int k = 1; k <= 40; k++) begin
            drive(1'b1, 1'b0, 16, WIDTH'(k * 7 + 1), 1'b1);
            tick("d16");
        end

        for (int k = 0; k < 20; k++) begin
            drive(1'b1, 1'b0, 20, WIDTH'($urandom), 1'b1);
            tick("d20");
        end
        check_val("d20_clamp", 32'(DELAY_CLAMP), 32'd1);
        for (int k = 0; k < 12; k++) begin
            drive(1'b1, 1'b0, 5, WIDTH'($urandom), 1'b1);
            tick("d5");
        end

        for (int k = 0; k < 16; k++) begin
            drive((k % 4 == 0) || (k % 4 == 3), 1'b0, 2, WIDTH'($urandom), 1'b1);
            tick("stall");
        end

        for (int k = 0; k < 12; k++) begin
            drive(1'b1, (k == 6), 4, WIDTH'($urandom), 1'b1);
            tick("flush");
        end

        for (int k = 0; k < 16; k++) begin
            drive(1'b1, 1'b0, 3, WIDTH'($urandom_range(1, 4095)), ($urandom_range(0, 1) == 1));
            tick("vld");
        end

        RESET = 1'b1;
        drive(1'b1, 1'b1, 7, 12'h555, 1'b1);
        tick("rstmix");
        RESET = 1'b0;

        // Random soak: delay changes, stalls, flushes and resets at low rates
        begin
            int dly = 4;
            for (int k = 0; k < 2500; k++) begin
                if ($urandom_range(0, 49) == 0) dly = $urandom_range(0, 31);
                RESET = ($urandom_range(0, 299) == 0);
                drive(($urandom_range(0, 3) != 0), ($urandom_range(0, 99) == 0), dly,
                      WIDTH'($urandom), ($urandom_range(0, 4) != 0));
                tick("rnd");
            end
            RESET = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
